// File: rtl/tank_move_ctrl.sv
// Per-tank motion controller: sub-pixel position stepped once per frame from a 4-key pad,
// clamped to screen bounds, rolled back on blocking collisions, with a shell-kill/respawn FSM.
module tank_move_ctrl #(
    parameter int COORD_W        = 11,
    parameter int FRAC_BITS      = 6,
    parameter int INITIAL_X      = 280,
    parameter int INITIAL_Y      = 185,
    parameter int INITIAL_DIR    = 1,
    parameter int SPEED          = 20,
    parameter int MIN_X          = 0,
    parameter int MAX_X          = 599,
    parameter int MIN_Y          = 0,
    parameter int MAX_Y          = 439,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic [3:0]         inputKeyPressed,
    input  logic               brickCollision,
    input  logic               tankCollision,
    input  logic               missleCollision,
    output logic [COORD_W-1:0] topLeftX,
    output logic [COORD_W-1:0] topLeftY,
    output logic [1:0]         tankDir,
    output logic               alive,
    output logic               respawnPulse,
    output logic               state_dbg
);

    localparam int POS_W = COORD_W + FRAC_BITS;
    localparam int SUM_W = POS_W + 1;
    localparam int CNT_W = (RESPAWN_FRAMES > 0) ? $clog2(RESPAWN_FRAMES + 1) : 1;

    localparam logic [POS_W-1:0] SPAWN_X = POS_W'(INITIAL_X << FRAC_BITS);
    localparam logic [POS_W-1:0] SPAWN_Y = POS_W'(INITIAL_Y << FRAC_BITS);
    localparam logic signed [SUM_W-1:0] LO_X = SUM_W'(MIN_X << FRAC_BITS);
    localparam logic signed [SUM_W-1:0] HI_X = SUM_W'(MAX_X << FRAC_BITS);
    localparam logic signed [SUM_W-1:0] LO_Y = SUM_W'(MIN_Y << FRAC_BITS);
    localparam logic signed [SUM_W-1:0] HI_Y = SUM_W'(MAX_Y << FRAC_BITS);
    localparam logic signed [SUM_W-1:0] STEP = SUM_W'(SPEED);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RESPAWN_FRAMES);

    typedef enum logic {ALIVE, DEAD} state_t;

    state_t             state;
    logic [POS_W-1:0]   pos_x, pos_y, prev_x, prev_y;
    logic               block_arm;
    logic [CNT_W-1:0]   cnt;

    logic signed [SUM_W-1:0] step_x, step_y, sum_x, sum_y;
    logic [POS_W-1:0]        next_x, next_y;
    logic                    key_valid;
    logic [1:0]              key_dir;

    // Negative sums fall below lo and therefore land on the lower bound.
    function automatic logic [POS_W-1:0] clamp(input logic signed [SUM_W-1:0] v,
                                               input logic signed [SUM_W-1:0] lo,
                                               input logic signed [SUM_W-1:0] hi);
        if (v < lo)
            return lo[POS_W-1:0];
        else if (v > hi)
            return hi[POS_W-1:0];
        else
            return v[POS_W-1:0];
    endfunction

    always_comb begin
        step_x    = '0;
        step_y    = '0;
        key_valid = 1'b0;
        key_dir   = tankDir;
        case (inputKeyPressed)
            4'b0001: begin step_y =  STEP; key_valid = 1'b1; key_dir = 2'd2; end
            4'b0010: begin step_y = -STEP; key_valid = 1'b1; key_dir = 2'd0; end
            4'b0100: begin step_x = -STEP; key_valid = 1'b1; key_dir = 2'd3; end
            4'b1000: begin step_x =  STEP; key_valid = 1'b1; key_dir = 2'd1; end
            default: ;
        endcase
        sum_x  = $signed({1'b0, pos_x}) + step_x;
        sum_y  = $signed({1'b0, pos_y}) + step_y;
        next_x = clamp(sum_x, LO_X, HI_X);
        next_y = clamp(sum_y, LO_Y, HI_Y);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ALIVE;
            pos_x        <= SPAWN_X;
            pos_y        <= SPAWN_Y;
            prev_x       <= SPAWN_X;
            prev_y       <= SPAWN_Y;
            tankDir      <= 2'(INITIAL_DIR);
            alive        <= 1'b1;
            respawnPulse <= 1'b0;
            block_arm    <= 1'b1;
            cnt          <= '0;
        end else begin
            respawnPulse <= 1'b0;
            case (state)
                ALIVE: begin
                    if (missleCollision) begin
                        state <= DEAD;
                        alive <= 1'b0;
                        cnt   <= CNT_INIT;
                    end else if ((brickCollision || tankCollision) && block_arm) begin
                        // One rollback per frame even if the collision is held.
                        pos_x     <= prev_x;
                        pos_y     <= prev_y;
                        block_arm <= 1'b0;
                    end else if (startOfFrame) begin
                        prev_x    <= pos_x;
                        prev_y    <= pos_y;
                        pos_x     <= next_x;
                        pos_y     <= next_y;
                        block_arm <= 1'b1;
                        if (key_valid)
                            tankDir <= key_dir;
                    end
                end
                DEAD: begin
                    if (startOfFrame) begin
                        if (cnt == '0) begin
                            state        <= ALIVE;
                            pos_x        <= SPAWN_X;
                            pos_y        <= SPAWN_Y;
                            prev_x       <= SPAWN_X;
                            prev_y       <= SPAWN_Y;
                            tankDir      <= 2'(INITIAL_DIR);
                            alive        <= 1'b1;
                            respawnPulse <= 1'b1;
                            block_arm    <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign topLeftX  = pos_x[POS_W-1:FRAC_BITS];
    assign topLeftY  = pos_y[POS_W-1:FRAC_BITS];
    assign state_dbg = (state == DEAD);

endmodule

// File: tb/tb_tank_move_ctrl.sv
// Bench for tank_move_ctrl: directed scenarios plus random traffic, checked against
// a sub-pixel integer model of the motion and respawn rules.
module tb_tank_move_ctrl;

  localparam int COORD_W = 11;
  localparam int FRAC    = 6;
  localparam int SPD     = 20;
  localparam int SPX     = 280 * 64;
  localparam int SPY     = 185 * 64;
  localparam int SP_DIR  = 1;
  localparam int RESP    = 60;
  localparam int LOX = 0, HIX = 599 * 64, LOY = 0, HIY = 439 * 64;
  localparam int VW = 2 * COORD_W + 4;

  logic clk = 1'b0;
  logic reset;
  logic startOfFrame;
  logic [3:0] inputKeyPressed;
  logic brickCollision, tankCollision, missleCollision;
  logic [COORD_W-1:0] topLeftX, topLeftY;
  logic [1:0] tankDir;
  logic alive, respawnPulse, state_dbg;

  int checks = 0;
  int errors = 0;

  int mx, my, px, py, mdir, malive, mpulse, mcnt, marm;
  logic [VW-1:0] exp_q[$];

  tank_move_ctrl dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .inputKeyPressed(inputKeyPressed), .brickCollision(brickCollision),
    .tankCollision(tankCollision), .missleCollision(missleCollision),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .tankDir(tankDir),
    .alive(alive), .respawnPulse(respawnPulse), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // reference model
  function automatic int lim(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    mx = SPX; my = SPY; px = SPX; py = SPY;
    mdir = SP_DIR; malive = 1; mpulse = 0; mcnt = 0; marm = 1;
  endtask

  task automatic model_cycle(input bit sof, input logic [3:0] k, input bit br, input bit tk,
                             input bit ms);
    int dx, dy, nd;
    bit one_hot;
    mpulse = 0;
    if (malive == 1) begin
      if (ms) begin
        malive = 0;
        mcnt = RESP;
      end else if ((br || tk) && marm == 1) begin
        mx = px; my = py; marm = 0;
      end else if (sof) begin
        dx = 0; dy = 0; nd = mdir;
        one_hot = ($countones(k) == 1);
        if (one_hot) begin
          if (k[0]) begin dy = SPD;  nd = 2; end
          if (k[1]) begin dy = -SPD; nd = 0; end
          if (k[2]) begin dx = -SPD; nd = 3; end
          if (k[3]) begin dx = SPD;  nd = 1; end
        end
        px = mx; py = my;
        mx = lim(mx + dx, LOX, HIX);
        my = lim(my + dy, LOY, HIY);
        mdir = nd;
        marm = 1;
      end
    end else if (sof) begin
      if (mcnt == 0) model_reset_respawn();
      else mcnt = mcnt - 1;
    end
  endtask

  task automatic model_reset_respawn();
    model_reset();
    mpulse = 1;
  endtask

  // scoreboard
  task automatic check_all(input string tag);
    logic [VW-1:0] e, obs;
    exp_q.push_back({COORD_W'(mx / 64), COORD_W'(my / 64), 2'(mdir), 1'(malive), 1'(mpulse)});
    obs = {topLeftX, topLeftY, tankDir, alive, respawnPulse};
    e = exp_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed x=%0d y=%0d dir=%0d alive=%0b pulse=%0b expected x=%0d y=%0d dir=%0d alive=%0b pulse=%0b",
             tag, obs[VW-1 -: COORD_W], obs[VW-1-COORD_W -: COORD_W], obs[3:2], obs[1], obs[0],
             e[VW-1 -: COORD_W], e[VW-1-COORD_W -: COORD_W], e[3:2], e[1], e[0]);
    end
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic tick(input bit sof, input logic [3:0] k, input bit br, input bit tk,
                      input bit ms, input string tag);
    startOfFrame = sof; inputKeyPressed = k;
    brickCollision = br; tankCollision = tk; missleCollision = ms;
    @(posedge clk);
    #1;
    model_cycle(sof, k, br, tk, ms);
    check_all(tag);
  endtask

  task automatic frame(input logic [3:0] k, input string tag);
    tick(1'b1, k, 1'b0, 1'b0, 1'b0, tag);
    tick(1'b0, k, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [3:0] rk;
    reset = 1'b0; startOfFrame = 1'b0; inputKeyPressed = 4'b0;
    brickCollision = 1'b0; tankCollision = 1'b0; missleCollision = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset("reset");
    check_val("reset_x", int'(topLeftX), 280);
    check_val("reset_y", int'(topLeftY), 185);
    check_val("reset_dir", int'(tankDir), 1);
    check_val("reset_alive", int'(alive), 1);
    check_val("reset_pulse", int'(respawnPulse), 0);

    repeat (64) frame(4'b1000, "right64");
    check_val("right64_x", int'(topLeftX), 300);
    check_val("right64_y", int'(topLeftY), 185);
    check_val("right64_dir", int'(tankDir), 1);

    repeat (10) frame(4'b0101, "two_keys");
    check_val("two_keys_x", int'(topLeftX), 300);
    check_val("two_keys_y", int'(topLeftY), 185);
    check_val("two_keys_dir", int'(tankDir), 1);

    repeat (1100) frame(4'b1000, "to_right_edge");
    check_val("clamp_max_x", int'(topLeftX), 599);
    repeat (5) frame(4'b1000, "hold_right_edge");
    check_val("clamp_max_hold", int'(topLeftX), 599);
    repeat (2000) frame(4'b0100, "to_left_edge");
    check_val("clamp_min_x", int'(topLeftX), 0);
    check_val("clamp_min_dir", int'(tankDir), 3);

    // 4 steps of 20 sub-pixels cross into pixel 1; rollback returns to 60 (pixel 0).
    repeat (4) frame(4'b1000, "pre_brick");
    check_val("pre_brick_x", int'(topLeftX), 1);
    repeat (3) tick(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, "brick_hold");
    check_val("brick_rollback_x", int'(topLeftX), 0);
    frame(4'b1000, "post_brick");
    check_val("post_brick_x", int'(topLeftX), 1);
    tick(1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, "tank_on_sof");
    check_val("tank_on_sof_x", int'(topLeftX), 0);

    tick(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, "kill");
    check_val("kill_alive", int'(alive), 0);
    repeat (60) begin
      tick(1'b1, 4'b0001, 1'b1, 1'b0, 1'b1, "dead_sof");
      tick(1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, "dead_idle");
    end
    check_val("dead_alive", int'(alive), 0);
    tick(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, "respawn");
    check_val("respawn_pulse", int'(respawnPulse), 1);
    check_val("respawn_x", int'(topLeftX), 280);
    check_val("respawn_y", int'(topLeftY), 185);
    check_val("respawn_dir", int'(tankDir), 1);
    tick(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, "pulse_clear");
    check_val("pulse_clear", int'(respawnPulse), 0);

    frame(4'b0010, "up_step");
    tick(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, "kill2");
    repeat (5) frame(4'b0000, "dead2");
    do_reset("reset_dead");
    check_val("reset_dead_alive", int'(alive), 1);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) rk = 4'($urandom_range(0, 15));
      else rk = 4'(1 << $urandom_range(0, 3));
      tick(($urandom_range(0, 3) == 0), rk, ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
